// File: rtl/audio_pkg.sv
// Shared types and sizes for the audio line packer: sample, line and tag
// widths plus the buffer and output-FSM state encodings.
package audio_pkg;

  localparam int SAMPLES_PER_LINE = 32;
  localparam int SAMPLE_W         = 16;
  localparam int LINE_W           = 512;
  localparam int TAG_W            = 27;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [LINE_W-1:0]          line_t;
  typedef logic [TAG_W-1:0]           line_tag_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL
  } buf_state_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_PRESENT
  } out_state_t;

endpackage

// File: rtl/audio_line_packer_if.sv
// Sample-in / line-out bus of the audio line packer. The master modport is the
// environment (upstream effect stage plus downstream memory writer); slave is the packer.
interface audio_line_packer_if;
  import audio_pkg::*;

  logic        en;
  sample_t     audio_in;
  logic [31:0] address_in;
  logic        flush;
  logic        ready_for_data;
  line_t       line_data;
  line_tag_t   line_addr;
  logic        line_valid;
  logic        line_ready;
  logic        done;

  modport master (
    output en, audio_in, address_in, flush, line_ready,
    input  ready_for_data, line_data, line_addr, line_valid, done
  );

  modport slave (
    input  en, audio_in, address_in, flush, line_ready,
    output ready_for_data, line_data, line_addr, line_valid, done
  );

endinterface

// File: rtl/line_slot_buffer.sv
// One 512-bit line store with its line tag and EMPTY/FILLING/FULL state.
// Sequencing (which buffer fills, which one drains) is decided by the parent.
module line_slot_buffer
  import audio_pkg::*;
#(
  parameter int SLOTS = SAMPLES_PER_LINE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  sample_t                  wr_sample,
  input  line_tag_t                wr_tag,
  input  logic                     pad_en,
  input  logic [$clog2(SLOTS)-1:0] pad_from,
  input  logic                     set_full,
  input  logic                     drain,
  output line_t                    data,
  output line_tag_t                tag,
  output buf_state_t               state
);

  localparam int CNT_W = $clog2(SLOTS);

  // Padding covers slots >= pad_from; the parent passes the post-write count,
  // so a sample written in the same cycle is never overwritten by padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (wr_en && (wr_slot == CNT_W'(k)))
          data[k*SAMPLE_W +: SAMPLE_W] <= wr_sample;
        else if (pad_en && (CNT_W'(k) >= pad_from))
          data[k*SAMPLE_W +: SAMPLE_W] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      state <= BUF_EMPTY;
    end else begin
      if (wr_en && (wr_slot == '0))
        tag <= wr_tag;
      if (drain)
        state <= BUF_EMPTY;
      else if (set_full)
        state <= BUF_FULL;
      else if (wr_en)
        state <= BUF_FILLING;
    end
  end

endmodule

// File: rtl/audio_line_packer.sv
// Packs 16-bit audio samples into 512-bit lines through two ping-pong buffers,
// presents full lines in fill order and supports flush with a done pulse.
//
// Output FSM states:
//   state       | meaning
//   OUT_IDLE    | oldest buffer not FULL, line_valid low
//   OUT_PRESENT | oldest buffer FULL, line_valid high until line_ready
module audio_line_packer
  import audio_pkg::*;
#(
  parameter int SAMPLES_PER_LINE = audio_pkg::SAMPLES_PER_LINE
) (
  input logic                 clk,
  input logic                 rst_n,
  audio_line_packer_if.slave  bus
);

  localparam int                CNT_W     = $clog2(SAMPLES_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SAMPLES_PER_LINE - 1);

  out_state_t       out_state, out_state_nxt;
  logic [CNT_W-1:0] fill_cnt, cnt_after;
  logic             fill_sel, out_sel;
  logic             flush_pend, draining, done_q;
  logic [1:0]       lines_left, n_full_nxt;

  line_t      buf_data [2];
  line_tag_t  buf_tag  [2];
  buf_state_t buf_st   [2];

  logic [1:0] wr_en, pad_en, set_full, drain, full_nxt;
  logic       accept, last_slot, flush_req, flush_go, pad, mark_full, hs, fill_full;
  logic       unused_addr_lsb;

  // fill_sel only lands on a FULL buffer when both are FULL.
  assign fill_full          = (buf_st[fill_sel] == BUF_FULL);
  assign bus.ready_for_data = rst_n && !fill_full && !flush_pend;

  assign accept    = bus.en && bus.ready_for_data;
  assign last_slot = accept && (fill_cnt == LAST_SLOT);
  assign cnt_after = accept ? (last_slot ? '0 : fill_cnt + 1'b1) : fill_cnt;
  assign flush_req = bus.flush || flush_pend;
  assign flush_go  = flush_req && !fill_full;
  assign pad       = flush_go && (cnt_after != '0);
  assign mark_full = last_slot || pad;
  assign hs        = bus.line_valid && bus.line_ready;

  assign unused_addr_lsb = ^bus.address_in[4:0];

  always_comb begin
    wr_en    = '0;
    pad_en   = '0;
    set_full = '0;
    drain    = '0;
    full_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      wr_en[i]    = accept    && (fill_sel == 1'(i));
      pad_en[i]   = pad       && (fill_sel == 1'(i));
      set_full[i] = mark_full && (fill_sel == 1'(i));
      drain[i]    = hs        && (out_sel  == 1'(i));
      full_nxt[i] = ((buf_st[i] == BUF_FULL) && !drain[i]) || set_full[i];
    end
    n_full_nxt = {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
  end

  // Looking at full_nxt gives line_valid one cycle after the slot-31 accept.
  always_comb begin
    out_state_nxt = out_state;
    case (out_state)
      OUT_IDLE:    if (full_nxt[out_sel]) out_state_nxt = OUT_PRESENT;
      OUT_PRESENT: if (hs && !full_nxt[~out_sel]) out_state_nxt = OUT_IDLE;
      default:     out_state_nxt = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state  <= OUT_IDLE;
      fill_cnt   <= '0;
      fill_sel   <= 1'b0;
      out_sel    <= 1'b0;
      flush_pend <= 1'b0;
      draining   <= 1'b0;
      lines_left <= '0;
      done_q     <= 1'b0;
    end else begin
      out_state  <= out_state_nxt;
      fill_cnt   <= pad ? '0 : cnt_after;
      flush_pend <= flush_req && !flush_go;
      done_q     <= 1'b0;
      if (mark_full) fill_sel <= ~fill_sel;
      if (hs)        out_sel  <= ~out_sel;
      // Every line FULL after the flush cycle must drain before done.
      if (flush_go) begin
        if (n_full_nxt == 2'd0) begin
          done_q   <= 1'b1;
          draining <= 1'b0;
        end else begin
          draining   <= 1'b1;
          lines_left <= n_full_nxt;
        end
      end else if (draining && hs) begin
        lines_left <= lines_left - 1'b1;
        if (lines_left == 2'd1) begin
          done_q   <= 1'b1;
          draining <= 1'b0;
        end
      end
    end
  end

  assign bus.line_valid = (out_state == OUT_PRESENT);
  assign bus.line_data  = bus.line_valid ? buf_data[out_sel] : '0;
  assign bus.line_addr  = bus.line_valid ? buf_tag[out_sel]  : '0;
  assign bus.done       = done_q;

  line_slot_buffer #(.SLOTS(SAMPLES_PER_LINE)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en[0]),
    .wr_slot   (fill_cnt),
    .wr_sample (bus.audio_in),
    .wr_tag    (bus.address_in[31:5]),
    .pad_en    (pad_en[0]),
    .pad_from  (cnt_after),
    .set_full  (set_full[0]),
    .drain     (drain[0]),
    .data      (buf_data[0]),
    .tag       (buf_tag[0]),
    .state     (buf_st[0])
  );

  line_slot_buffer #(.SLOTS(SAMPLES_PER_LINE)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en[1]),
    .wr_slot   (fill_cnt),
    .wr_sample (bus.audio_in),
    .wr_tag    (bus.address_in[31:5]),
    .pad_en    (pad_en[1]),
    .pad_from  (cnt_after),
    .set_full  (set_full[1]),
    .drain     (drain[1]),
    .data      (buf_data[1]),
    .tag       (buf_tag[1]),
    .state     (buf_st[1])
  );

endmodule

// File: doc/audio_line_packer.md
AUDIO_LINE_PACKER -- requirements
Module: audio_line_packer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_LINE, default 32, number of 16-bit samples per 512-bit output line.
REQ-002 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, audio_in/address_in valid this cycle (driven by upstream effect stage).
REQ-005 SHALL have port audio_in, input, signed 16, processed sample from upstream stage.
REQ-006 SHALL have port address_in, input, 32, sample index accompanying audio_in.
REQ-007 SHALL have port flush, input, 1, single-cycle request to emit any partial line.
REQ-008 SHALL have port ready_for_data, output, 1, high when a sample can be accepted this cycle.
REQ-009 SHALL have port line_data, output, 512, packed line; slot k at bits [16k+15:16k].
REQ-010 SHALL have port line_addr, output, 27, address_in[31:5] of slot-0 sample of the line.
REQ-011 SHALL have port line_valid, output, 1, line_data/line_addr valid.
REQ-012 SHALL have port line_ready, input, 1, downstream memory writer accepts line.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a flush has fully drained.

Function
REQ-014 Sample accepted SHALL be en && ready_for_data; en while ready_for_data low is dropped, not buffered.
REQ-015 Two line buffers SHALL be used ping-pong; each has state EMPTY, FILLING or FULL.
REQ-016 Accepted samples SHALL be written to slot = fill counter (0..31) of the filling buffer; counter increments, wraps 31->0.
REQ-017 On slot-0 write, buffer SHALL latch address_in[31:5] as its line tag; later addresses are not checked.
REQ-018 Slot-31 write SHALL mark buffer FULL and switch filling to the other buffer if EMPTY.
REQ-019 ready_for_data SHALL be low only when both buffers are FULL, or flush is pending.
REQ-020 Output FSM SHALL have states IDLE and PRESENT; IDLE->PRESENT when oldest buffer FULL, line_valid asserted next cycle after slot-31 accept (latency 1).
REQ-021 In PRESENT, line_data/line_addr SHALL stay stable until line_valid && line_ready; that cycle buffer becomes EMPTY and FSM returns to IDLE or, if other buffer FULL, remains PRESENT with it next cycle.
REQ-022 Lines SHALL be emitted in fill order.
REQ-023 Flush with fill counter >0 SHALL zero-fill remaining slots, mark buffer FULL, reset counter to 0.
REQ-024 Flush with fill counter 0 and no FULL buffers SHALL pulse done next cycle, no line emitted.
REQ-025 Flush with accept in same cycle SHALL include that sample before padding.
REQ-026 Flush while both buffers FULL SHALL be held pending (ready_for_data low) until a buffer frees, then applied.
REQ-027 done SHALL pulse the cycle after the last line created by or before the flush handshakes.
REQ-028 flush while a prior flush is pending SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately clear: both buffers EMPTY, fill counter 0, flush pending 0, FSM IDLE.
REQ-030 Reset outputs SHALL be line_valid 0, done 0, line_data 0, line_addr 0, ready_for_data 0 during reset, 1 first cycle after release.
REQ-031 Reset mid-line or mid-handshake SHALL discard all buffered samples; no line emitted afterwards for them.

Structure
REQ-032 Shared package audio_pkg SHALL hold SAMPLES_PER_LINE, sample_t (signed 16), line_t (512), line_tag_t (27).
REQ-033 One sub-module line_slot_buffer (512-bit store, tag, state) SHALL be instantiated twice; control stays in top.

Verification
REQ-034 rst release, en=1 for 32 cycles, address_in 0..31, audio_in=i*100, line_ready=1 -> one line, line_addr 0, slot k = k*100, line_valid 1 cycle after accept 31.
REQ-035 Stream 96 samples from address 0x40, line_ready=0 -> ready_for_data falls after sample 64, two lines held; raise line_ready -> tags 0x2, 0x3 in order, then 0x4.
REQ-036 10 samples 0x7FFF then flush -> line slots 0..9 = 0x7FFF, 10..31 = 0, done pulse after handshake.
REQ-037 Flush with nothing buffered -> done next cycle, line_valid stays 0.
REQ-038 Both buffers full, flush asserted, line_ready later 1 -> flush applied after first drain, done after last line.
REQ-039 rst_n low after 20 samples during line_valid -> line_valid 0 immediately; 32 new samples produce line with only new data.
